// File: rtl/ldtu_pkg.sv
// Shared LiTE-DTU definitions: word headers, word-type decode, field offsets and
// sample extraction. Used by both the stream decoder and the DTU encoder side.
package ldtu_pkg;

  localparam int unsigned Nbits_12 = 12;
  localparam int unsigned Nbits_32 = 32;
  localparam int unsigned crcBits  = 12;
  localparam logic [crcBits-1:0] CRC_POLY = 12'h80F;

  localparam logic [1:0] HdrBase5   = 2'b01;
  localparam logic [3:0] HdrBaseN   = 4'b0010;
  localparam logic [5:0] HdrSig2    = 6'b001010;
  localparam logic [5:0] HdrSig1    = 6'b001011;
  localparam logic [3:0] HdrTrailer = 4'b1101;
  localparam logic [3:0] HdrIdle    = 4'b1110;

  localparam int unsigned TrlCntLsb  = 20;
  localparam int unsigned TrlCrcLsb  = 8;
  localparam int unsigned TrlFnumLsb = 0;
  localparam int unsigned SigS1Lsb   = 13;

  typedef enum logic [2:0] {
    WtBase5, WtBaseN, WtSig2, WtSig1, WtTrailer, WtIdle, WtInvalid
  } word_type_e;

  typedef enum logic {StIdle, StUnpack} dec_state_e;

  typedef struct packed {
    logic                value_valid;
    logic                baseline;
    logic                gain;
    logic [Nbits_12-1:0] value;
  } sample_t;

  // Signal headers share the 0010 prefix with partial baseline, so test them first.
  function automatic word_type_e decode_word(input logic [Nbits_32-1:0] w);
    word_type_e t;
    if (w[31:30] == HdrBase5) begin
      t = WtBase5;
    end else if (w[31:26] == HdrSig2) begin
      t = WtSig2;
    end else if (w[31:26] == HdrSig1) begin
      t = WtSig1;
    end else if (w[31:28] == HdrBaseN) begin
      t = (w[27:24] >= 4'd1 && w[27:24] <= 4'd4) ? WtBaseN : WtInvalid;
    end else if (w[31:28] == HdrTrailer) begin
      t = WtTrailer;
    end else if (w[31:28] == HdrIdle) begin
      t = WtIdle;
    end else begin
      t = WtInvalid;
    end
    return t;
  endfunction

  function automatic logic [2:0] word_samples(input word_type_e t,
                                              input logic [Nbits_32-1:0] w);
    logic [2:0] n;
    case (t)
      WtBase5: n = 3'd5;
      WtBaseN: n = w[26:24];
      WtSig2:  n = 3'd2;
      WtSig1:  n = 3'd1;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic sample_t word_sample(input logic [Nbits_32-1:0] w, input word_type_e t,
                                          input logic [2:0] idx);
    sample_t s;
    logic [Nbits_32-1:0] sh;
    s  = '0;
    sh = w >> (6 * idx);
    case (t)
      WtBase5, WtBaseN: begin
        s.baseline = 1'b1;
        s.value    = {6'b0, sh[5:0]};
      end
      WtSig2, WtSig1: begin
        s.gain  = (idx == 3'd0) ? w[12] : w[SigS1Lsb+12];
        s.value = (idx == 3'd0) ? w[11:0] : w[SigS1Lsb+11:SigS1Lsb];
      end
      default: s = '0;
    endcase
    s.value_valid = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/ldtu_crc12_word.sv
// Combinational CRC-12 update over one 32-bit word, MSB first.
module ldtu_crc12_word
  import ldtu_pkg::*;
(
  input  logic [crcBits-1:0]  crc_i,
  input  logic [Nbits_32-1:0] data_i,
  output logic [crcBits-1:0]  crc_o
);

  logic [crcBits-1:0] crc_acc;
  logic               fb;

  always_comb begin
    crc_acc = crc_i;
    fb      = 1'b0;
    for (int i = Nbits_32 - 1; i >= 0; i--) begin
      fb      = crc_acc[crcBits-1] ^ data_i[i];
      crc_acc = {crc_acc[crcBits-2:0], 1'b0};
      if (fb) begin
        crc_acc = crc_acc ^ CRC_POLY;
      end
    end
    crc_o = crc_acc;
  end

endmodule

// File: rtl/ldtu_stream_decoder.sv
// Receive-side LiTE-DTU lane decoder: unpacks data words into one sample per cycle and
// checks each frame trailer for CRC, sample count and frame number continuity.
module ldtu_stream_decoder
  import ldtu_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic [Nbits_32-1:0] DATA32_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic [Nbits_12-1:0] sample_out,
  output logic                gain_out,
  output logic                baseline_out,
  output logic                sample_valid,
  output logic                frame_done,
  output logic                crc_error,
  output logic                count_error,
  output logic                fnum_error,
  output logic [7:0]          frame_num,
  output logic                invalid_word
);

  dec_state_e          state_q;
  logic [Nbits_32-1:0] word_q;
  word_type_e          type_q;
  logic [2:0]          idx_q;
  logic [2:0]          rem_q;
  logic [crcBits-1:0]  crc_q;
  logic [7:0]          cnt_q;
  logic                first_q;
  logic [7:0]          frame_num_q;

  logic [Nbits_12-1:0] sample_q;
  logic                gain_q;
  logic                baseline_q;
  logic                sample_valid_q;
  logic                frame_done_q;
  logic                crc_error_q;
  logic                count_error_q;
  logic                fnum_error_q;
  logic                invalid_q;

  logic                accept;
  word_type_e          in_type;
  logic [2:0]          in_n;
  sample_t             in_smp;
  sample_t             cur_smp;
  logic [crcBits-1:0]  crc_d;
  logic [7:0]          trl_cnt;
  logic [crcBits-1:0]  trl_crc;
  logic [7:0]          trl_fnum;

  // The cycle showing a word's last sample is already back in StIdle, which gives
  // back-to-back acceptance without a bubble.
  assign data_ready = (state_q == StIdle) && !RST;
  assign accept     = data_valid && data_ready;

  always_comb begin
    in_type  = decode_word(DATA32_in);
    in_n     = word_samples(in_type, DATA32_in);
    in_smp   = word_sample(DATA32_in, in_type, 3'd0);
    cur_smp  = word_sample(word_q, type_q, idx_q);
    trl_cnt  = DATA32_in[TrlCntLsb +: 8];
    trl_crc  = DATA32_in[TrlCrcLsb +: crcBits];
    trl_fnum = DATA32_in[TrlFnumLsb +: 8];
  end

  ldtu_crc12_word u_crc (
    .crc_i  (crc_q),
    .data_i (DATA32_in),
    .crc_o  (crc_d)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= StIdle;
      word_q         <= '0;
      type_q         <= WtIdle;
      idx_q          <= '0;
      rem_q          <= '0;
      crc_q          <= '0;
      cnt_q          <= '0;
      first_q        <= 1'b1;
      frame_num_q    <= '0;
      sample_q       <= '0;
      gain_q         <= 1'b0;
      baseline_q     <= 1'b0;
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      crc_error_q    <= 1'b0;
      count_error_q  <= 1'b0;
      fnum_error_q   <= 1'b0;
      invalid_q      <= 1'b0;
    end else begin
      sample_valid_q <= 1'b0;
      frame_done_q   <= 1'b0;
      invalid_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            unique case (in_type)
              WtBase5, WtBaseN, WtSig2, WtSig1: begin
                crc_q          <= crc_d;
                cnt_q          <= cnt_q + {5'b0, in_n};
                word_q         <= DATA32_in;
                type_q         <= in_type;
                sample_q       <= in_smp.value;
                gain_q         <= in_smp.gain;
                baseline_q     <= in_smp.baseline;
                sample_valid_q <= 1'b1;
                idx_q          <= 3'd1;
                rem_q          <= in_n - 3'd1;
                if (in_n > 3'd1) begin
                  state_q <= StUnpack;
                end
              end
              WtTrailer: begin
                frame_done_q  <= 1'b1;
                crc_error_q   <= (trl_crc != crc_q);
                count_error_q <= (trl_cnt != cnt_q);
                fnum_error_q  <= !first_q && (trl_fnum != frame_num_q + 8'd1);
                frame_num_q   <= trl_fnum;
                first_q       <= 1'b0;
                crc_q         <= '0;
                cnt_q         <= '0;
              end
              WtIdle: begin
              end
              default: invalid_q <= 1'b1;
            endcase
          end
        end
        StUnpack: begin
          sample_q       <= cur_smp.value;
          gain_q         <= cur_smp.gain;
          baseline_q     <= cur_smp.baseline;
          sample_valid_q <= 1'b1;
          idx_q          <= idx_q + 3'd1;
          rem_q          <= rem_q - 3'd1;
          if (rem_q == 3'd1) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sample_out   = sample_q;
  assign gain_out     = gain_q;
  assign baseline_out = baseline_q;
  assign sample_valid = sample_valid_q;
  assign frame_done   = frame_done_q;
  assign crc_error    = crc_error_q;
  assign count_error  = count_error_q;
  assign fnum_error   = fnum_error_q;
  assign frame_num    = frame_num_q;
  assign invalid_word = invalid_q;

endmodule

// File: tb/tb_ldtu_stream_decoder.sv
// Scoreboard bench for ldtu_stream_decoder: stimulus pushes expected samples and trailer
// results, a negedge monitor pops and compares whatever the decoder presents.
module tb_ldtu_stream_decoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] DATA32_in = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic [11:0] sample_out;
  logic        gain_out, baseline_out, sample_valid, frame_done;
  logic        crc_error, count_error, fnum_error, invalid_word;
  logic [7:0]  frame_num;

  always #5 CLK = ~CLK;

  ldtu_stream_decoder dut (
    .CLK          (CLK),
    .RST          (RST),
    .DATA32_in    (DATA32_in),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .sample_out   (sample_out),
    .gain_out     (gain_out),
    .baseline_out (baseline_out),
    .sample_valid (sample_valid),
    .frame_done   (frame_done),
    .crc_error    (crc_error),
    .count_error  (count_error),
    .fnum_error   (fnum_error),
    .frame_num    (frame_num),
    .invalid_word (invalid_word)
  );

  typedef struct {
    logic [11:0] v;
    logic        g;
    logic        b;
    logic        contig;
  } smp_t;

  typedef struct {
    logic       ce;
    logic       ne;
    logic       fe;
    logic [7:0] fn;
  } frm_t;

  smp_t exp_s[$];
  frm_t exp_f[$];
  logic frame_bits[$];
  int   exp_inv = 0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference CRC: remainder of (frame bits * x^12) divided by x^12+x^11+x^3+x^2+x+1.
  function automatic logic [11:0] model_crc();
    logic [12:0] r;
    r = '0;
    foreach (frame_bits[i]) begin
      r = {r[11:0], frame_bits[i]};
      if (r[12]) r = r ^ 13'h180F;
    end
    for (int i = 0; i < 12; i++) begin
      r = {r[11:0], 1'b0};
      if (r[12]) r = r ^ 13'h180F;
    end
    return r[11:0];
  endfunction

  task automatic push_s(input logic [11:0] v, input logic g, input logic b, input logic c);
    smp_t e;
    e.v = v; e.g = g; e.b = b; e.contig = c;
    exp_s.push_back(e);
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    DATA32_in  = w;
    data_valid = 1'b1;
    @(negedge CLK);
    while (data_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge CLK);
    end
    if (n >= 50) check("send_timeout", 32'd1, 32'd0);
    @(posedge CLK);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic send_data(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) frame_bits.push_back(w[i]);
    send(w);
  endtask

  task automatic send_trailer(input logic [7:0] cnt, input logic [11:0] crc_flip,
                              input logic [7:0] fn, input logic ce, input logic ne,
                              input logic fe);
    frm_t f;
    logic [11:0] crc;
    crc = model_crc() ^ crc_flip;
    f.ce = ce; f.ne = ne; f.fe = fe; f.fn = fn;
    exp_f.push_back(f);
    frame_bits.delete();
    send({4'hD, cnt, crc, fn});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_s.size() != 0 || exp_f.size() != 0 || exp_inv != 0) && n < 30) begin
      n++;
      @(posedge CLK);
    end
    repeat (4) @(posedge CLK);
    #1;
    check("drain_samples", exp_s.size(), 0);
    check("drain_frames", exp_f.size(), 0);
    check("drain_invalid", exp_inv, 0);
  endtask

  task automatic do_reset();
    data_valid = 1'b0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_data_ready", data_ready, 0);
    check("rst_sample_valid", sample_valid, 0);
    check("rst_frame_num", frame_num, 0);
    check("rst_frame_done", frame_done, 0);
    RST = 1'b0;
    frame_bits.delete();
    #1;
    check("ready_after_rst", data_ready, 1);
  endtask

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    smp_t e;
    frm_t f;
    if (sample_valid === 1'b1) begin
      if (exp_s.size() == 0) begin
        check("unexpected_sample", {20'd0, sample_out}, 32'hFFFF_FFFF);
      end else begin
        e = exp_s.pop_front();
        check("sample_value", sample_out, e.v);
        check("sample_gain", gain_out, e.g);
        check("sample_baseline", baseline_out, e.b);
        if (e.contig) check("sample_gap", cyc, last_cyc + 1);
      end
      last_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      if (exp_f.size() == 0) begin
        check("unexpected_frame_done", 32'd1, 32'd0);
      end else begin
        f = exp_f.pop_front();
        check("crc_error", crc_error, f.ce);
        check("count_error", count_error, f.ne);
        check("fnum_error", fnum_error, f.fe);
        check("frame_num", frame_num, f.fn);
      end
    end
    if (invalid_word === 1'b1) begin
      check("invalid_expected", (exp_inv > 0), 1);
      if (exp_inv > 0) exp_inv--;
    end
  end

  // Pushes the expected samples of 0x41083041 (values 1,1,3,2,1) and a 2-sample signal word.
  task automatic frame7(input logic first_contig);
    push_s(12'd1, 1'b0, 1'b1, first_contig);
    push_s(12'd1, 1'b0, 1'b1, 1'b1);
    push_s(12'd3, 1'b0, 1'b1, 1'b1);
    push_s(12'd2, 1'b0, 1'b1, 1'b1);
    push_s(12'd1, 1'b0, 1'b1, 1'b1);
    send_data(32'h4108_3041);
    push_s(12'h123, 1'b0, 1'b0, 1'b1);
    push_s(12'hABC, 1'b1, 1'b0, 1'b1);
    send_data(32'h2B57_8123);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Good frames 0x00 then 0x01, back-to-back words.
    do_reset();
    frame7(1'b0);
    send_trailer(8'd7, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    frame7(1'b0);
    push_s(12'hFFF, 1'b0, 1'b0, 1'b1);
    send_data(32'h2C00_0FFF);
    send_trailer(8'd8, 12'h000, 8'h01, 1'b0, 1'b0, 1'b0);
    drain();

    // Wrong CRC.
    do_reset();
    frame7(1'b0);
    send_trailer(8'd7, 12'h001, 8'h00, 1'b1, 1'b0, 1'b0);
    drain();

    // Wrong count.
    do_reset();
    frame7(1'b0);
    send_trailer(8'd6, 12'h000, 8'h00, 1'b0, 1'b1, 1'b0);
    drain();

    // Frame number jump 0x01 -> 0x03.
    do_reset();
    frame7(1'b0);
    send_trailer(8'd7, 12'h000, 8'h01, 1'b0, 1'b0, 1'b0);
    frame7(1'b0);
    send_trailer(8'd7, 12'h000, 8'h03, 1'b0, 1'b0, 1'b1);
    drain();

    // Invalid and idle words dropped; partial baseline N=3 (3,2,3).
    do_reset();
    push_s(12'd1, 1'b0, 1'b1, 1'b0);
    push_s(12'd1, 1'b0, 1'b1, 1'b1);
    push_s(12'd0, 1'b0, 1'b1, 1'b1);
    push_s(12'd2, 1'b0, 1'b1, 1'b1);
    push_s(12'd1, 1'b0, 1'b1, 1'b1);
    send_data(32'h4108_0041);
    send(32'hE000_0000);
    exp_inv++;
    send(32'hF000_0000);
    exp_inv++;
    send(32'h2000_0000);
    push_s(12'd3, 1'b0, 1'b1, 1'b0);
    push_s(12'd2, 1'b0, 1'b1, 1'b1);
    push_s(12'd3, 1'b0, 1'b1, 1'b1);
    send_data(32'h2300_3083);
    send(32'hE123_4567);
    push_s(12'hFFF, 1'b0, 1'b0, 1'b0);
    send_data(32'h2C00_0FFF);
    send_trailer(8'd9, 12'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    drain();

    // Reset during the third sample of a 5-sample word.
    do_reset();
    push_s(12'd1, 1'b0, 1'b1, 1'b0);
    push_s(12'd1, 1'b0, 1'b1, 1'b1);
    push_s(12'd3, 1'b0, 1'b1, 1'b1);
    send_data(32'h4108_3041);
    @(posedge CLK);
    #1;
    @(posedge CLK);
    #1;
    do_reset();
    repeat (6) @(posedge CLK);
    #1;
    send_trailer(8'd0, 12'h000, 8'h05, 1'b0, 1'b0, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
